// File: rtl/bus_cycle_initiator_if.sv
// rtl/bus_cycle_initiator_if.sv - request handshake and 8088-style bus signal bundle
interface bus_cycle_initiator_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic                  REQ;
  logic                  REQ_WR;
  logic                  REQ_IO;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  REQ_ACK;
  logic                  BUSY;
  logic                  DONE;
  logic                  ERR;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  ALE;
  logic                  IOM;
  logic                  RD;
  logic                  WR;
  logic                  READY;
  logic [ADDR_WIDTH-1:0] ADDRESS;

  modport master (
    input  REQ, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    output REQ_ACK, BUSY, DONE, ERR, RDATA, ALE, IOM, RD, WR, ADDRESS
  );

  modport slave (
    output REQ, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA, READY,
    input  REQ_ACK, BUSY, DONE, ERR, RDATA, ALE, IOM, RD, WR, ADDRESS
  );
endinterface

// File: rtl/bus_cycle_initiator.sv
// rtl/bus_cycle_initiator.sv - 8088-style T1-T2-T3-[TW]-T4 bus master for single read/write requests
module bus_cycle_initiator #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  CLK,
  input  logic                  RESET,
  bus_cycle_initiator_if.master bus,
  inout  wire  [DATA_WIDTH-1:0] DATA
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

  state_t                state;
  logic                  cyc_wr;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  data_oe;
  logic [7:0]            wait_cnt;
  logic                  ale_q;
  logic                  iom_q;
  logic                  rd_q;
  logic                  wr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign bus.REQ_ACK = (state == IDLE) & bus.REQ;
  assign bus.ALE     = ale_q;
  assign bus.IOM     = iom_q;
  assign bus.RD      = rd_q;
  assign bus.WR      = wr_q;
  assign bus.ADDRESS = addr_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;
  assign bus.RDATA   = rdata_q;
  assign DATA        = data_oe ? wdata_q : 'z;

  // Outputs are set on the edge entering the state they belong to.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= IDLE;
      cyc_wr   <= 1'b0;
      wdata_q  <= '0;
      data_oe  <= 1'b0;
      wait_cnt <= '0;
      ale_q    <= 1'b0;
      iom_q    <= 1'b0;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            state   <= T1;
            cyc_wr  <= bus.REQ_WR;
            iom_q   <= bus.REQ_IO;
            addr_q  <= bus.REQ_ADDR;
            wdata_q <= bus.REQ_WDATA;
            ale_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        T1: begin
          state <= T2;
          ale_q <= 1'b0;
          if (cyc_wr) begin
            wr_q    <= 1'b0;
            data_oe <= 1'b1;
          end else begin
            rd_q <= 1'b0;
          end
        end
        T2: state <= T3;
        T3, TW: begin
          if (bus.READY) begin
            state  <= T4;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            done_q <= 1'b1;
            if (!cyc_wr) rdata_q <= DATA;
          end else if (state == T3) begin
            state    <= TW;
            wait_cnt <= 8'd1;
          end else if (wait_cnt == 8'(MAX_WAIT)) begin
            // Responder never answered: close the cycle without touching RDATA.
            state  <= T4;
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        T4: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          data_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_cycle_initiator.sv
// tb/tb_bus_cycle_initiator.sv - randomized bench with a cycle-count reference model of the bus master
module tb_bus_cycle_initiator;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int MW = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_cycle_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  wire  [DW-1:0] data;
  logic [DW-1:0] rsp_data;

  assign data = (bus.RD == 1'b0) ? rsp_data : 'z;

  bus_cycle_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus),
    .DATA (data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chkv(name, {31'd0, act}, {31'd0, req});
  endtask

  // Responder: memory that answers reads while RD is low and latches writes while WR is low.
  logic [DW-1:0] rmem [logic [AW-1:0]];
  bit rsp_loaded = 0;
  always @(negedge clk) begin
    if (!rsp_loaded) begin
      rmem[19'h12345] = 8'hA5;
      rsp_loaded = 1;
    end
    if (bus.WR == 1'b0) rmem[bus.ADDRESS] = data;
    rsp_data = rmem.exists(bus.ADDRESS) ? rmem[bus.ADDRESS] : '0;
  end

  // Reference model: a transaction is k cycles old (T1 is k=1); T4 lands at k = 4 + waits.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            ref_loaded = 0;
  bit            run_chk = 0;
  bit            rst_applied = 0;
  int            cur_nw = 0;
  int            m_k = 0;
  int            m_nw = 0;
  int            m_waits = 0;
  int            t4;
  logic          m_wr = 0, m_io = 0, m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] rdata_exp = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  always @(negedge clk) begin
    if (!ref_loaded) begin
      ref_mem[19'h12345] = 8'hA5;
      ref_loaded = 1;
    end
    t4 = 4 + m_waits;
    if (run_chk) begin
      if (rst_applied) begin
        rdata_exp = '0;
        chkv("rst_address", 32'(bus.ADDRESS), 32'd0);
        chk1("rst_iom", bus.IOM, 1'b0);
      end
      if (m_k == 0) begin
        chk1("ack_idle", bus.REQ_ACK, bus.REQ);
        chk1("busy_idle", bus.BUSY, 1'b0);
        chk1("ale_idle", bus.ALE, 1'b0);
        chk1("rd_idle", bus.RD, 1'b1);
        chk1("wr_idle", bus.WR, 1'b1);
        chk1("done_idle", bus.DONE, 1'b0);
        chk1("err_idle", bus.ERR, 1'b0);
        chk1("oe_idle", dut.data_oe, 1'b0);
      end else begin
        if (m_k == 2 && m_wr) ref_mem[m_addr] = m_wdata;
        if (m_k == t4 && !m_wr && !m_err) rdata_exp = ref_rd(m_addr);
        chk1("ack_busy", bus.REQ_ACK, 1'b0);
        chk1("busy", bus.BUSY, 1'b1);
        chk1("ale", bus.ALE, m_k == 1);
        chkv("address", 32'(bus.ADDRESS), 32'(m_addr));
        chk1("iom", bus.IOM, m_io);
        chk1("rd", bus.RD, !(!m_wr && m_k >= 2 && m_k < t4));
        chk1("wr", bus.WR, !(m_wr && m_k >= 2 && m_k < t4));
        chk1("data_oe", dut.data_oe, m_wr && m_k >= 2);
        if (m_wr && m_k >= 2) chkv("wdata", 32'(data), 32'(m_wdata));
        chk1("done", bus.DONE, m_k == t4);
        chk1("err", bus.ERR, m_k == t4 && m_err);
      end
      chkv("rdata", 32'(bus.RDATA), 32'(rdata_exp));
    end
    // READY for this cycle: low for the first m_nw samples from T3, random where it is ignored.
    if (m_k >= 3 && m_k < t4) bus.READY = ((m_k - 3) >= m_nw);
    else bus.READY = 1'($urandom_range(0, 1));
    rst_applied = (rst_n == 1'b0);
    if (rst_n == 1'b0) begin
      m_k = 0;
    end else if (m_k == 0) begin
      if (bus.REQ) begin
        m_k     = 1;
        m_wr    = bus.REQ_WR;
        m_io    = bus.REQ_IO;
        m_addr  = bus.REQ_ADDR;
        m_wdata = bus.REQ_WDATA;
        m_nw    = cur_nw;
        m_err   = (cur_nw > MW);
        m_waits = m_err ? MW : cur_nw;
      end
    end else if (m_k == t4) begin
      m_k = 0;
    end else begin
      m_k++;
    end
  end

  task automatic do_txn(input logic wr, input logic io, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int nw, input bit keep,
                        output int ack_wait, output int lat);
    bus.REQ_WR    = wr;
    bus.REQ_IO    = io;
    bus.REQ_ADDR  = a;
    bus.REQ_WDATA = wd;
    cur_nw        = nw;
    bus.REQ       = 1'b1;
    ack_wait      = 0;
    lat           = 0;
    do begin
      @(negedge clk);
      ack_wait++;
    end while (!bus.REQ_ACK && ack_wait < 50);
    if (!bus.REQ_ACK) begin
      chk1("ack_timeout", 1'b0, 1'b1);
      bus.REQ = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) bus.REQ = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.DONE && lat < 300);
    if (!bus.DONE) chk1("done_timeout", 1'b0, 1'b1);
  endtask

  int            aw, lt;
  logic [AW-1:0] pool [6];

  initial begin
    pool[0] = 19'h12345; pool[1] = 19'h00060; pool[2] = 19'h00777;
    pool[3] = 19'h7FFFF; pool[4] = 19'h00000; pool[5] = 19'h2A5A5;
    rst_n = 1'b0;
    bus.REQ = 1'b0; bus.REQ_WR = 1'b0; bus.REQ_IO = 1'b0;
    bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_chk = 1;

    do_txn(1'b0, 1'b0, 19'h12345, 8'h00, 0, 0, aw, lt);
    chkv("mem_rd_latency", 32'(lt), 32'd4);
    chkv("mem_rd_data", 32'(bus.RDATA), 32'hA5);
    chk1("mem_rd_err", bus.ERR, 1'b0);

    do_txn(1'b1, 1'b1, 19'h00060, 8'h3C, 0, 0, aw, lt);
    chkv("io_wr_latency", 32'(lt), 32'd4);
    chkv("io_wr_responder", 32'(rmem[19'h00060]), 32'h3C);

    do_txn(1'b0, 1'b1, 19'h00060, 8'h00, 3, 0, aw, lt);
    chkv("wait3_latency", 32'(lt), 32'd7);
    chkv("wait3_data", 32'(bus.RDATA), 32'h3C);
    chk1("wait3_err", bus.ERR, 1'b0);

    do_txn(1'b0, 1'b0, 19'h12345, 8'h00, 40, 0, aw, lt);
    chkv("timeout_latency", 32'(lt), 32'd19);
    chk1("timeout_err", bus.ERR, 1'b1);
    chkv("timeout_rdata_kept", 32'(bus.RDATA), 32'h3C);
    @(negedge clk);
    chk1("timeout_busy_drop", bus.BUSY, 1'b0);

    // Reset while a write sits in TW.
    @(posedge clk);
    #1;
    bus.REQ_WR = 1'b1; bus.REQ_IO = 1'b0; bus.REQ_ADDR = 19'h00777; bus.REQ_WDATA = 8'h77;
    cur_nw = 40;
    bus.REQ = 1'b1;
    aw = 0;
    do begin
      @(negedge clk);
      aw++;
    end while (!bus.REQ_ACK && aw < 50);
    chk1("rst_ack", bus.REQ_ACK, 1'b1);
    @(posedge clk);
    #1;
    bus.REQ = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_wr_released", bus.WR, 1'b1);
    chk1("rst_data_z", dut.data_oe, 1'b0);
    chk1("rst_no_done", bus.DONE, 1'b0);

    do_txn(1'b0, 1'b0, 19'h00777, 8'h00, 0, 0, aw, lt);
    chkv("post_rst_latency", 32'(lt), 32'd4);
    chkv("post_rst_data", 32'(bus.RDATA), 32'h77);

    // Back-to-back with REQ held high.
    do_txn(1'b0, 1'b0, 19'h12345, 8'h00, 1, 1, aw, lt);
    do_txn(1'b1, 1'b0, 19'h00060, 8'h5A, 0, 0, aw, lt);
    chkv("b2b_ack_wait", 32'(aw), 32'd1);

    for (int i = 0; i < 60; i++) begin
      automatic logic          r_wr = 1'($urandom_range(0, 1));
      automatic logic          r_io = 1'($urandom_range(0, 1));
      automatic logic [AW-1:0] r_a  = pool[$urandom_range(0, 5)];
      automatic logic [DW-1:0] r_d  = 8'($urandom_range(0, 255));
      automatic int            r_nw = ($urandom_range(0, 7) == 0) ?
                                      int'($urandom_range(16, 18)) : int'($urandom_range(0, 4));
      automatic bit            r_k  = 1'($urandom_range(0, 1));
      do_txn(r_wr, r_io, r_a, r_d, r_nw, r_k, aw, lt);
      chkv("rand_latency", 32'(lt), 32'(4 + ((r_nw > MW) ? MW : r_nw)));
      if (!r_k) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    bus.REQ = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule
